// File: rtl/mux_rr_feeder.sv
// Round-robin feeder: one-word buffer per channel (a..d) with a registered select for a downstream 4:1 mux.
// Build option RR_SKIP_EMPTY_EN: an empty slot jumps straight to the next full channel instead of stepping by one.
module mux_rr_feeder #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic [1:0]         sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       skip_sel;
  logic [3:0]       load;
  logic             xfer;

  assign out_valid = full_q[sel_q];
  assign xfer      = out_valid & out_ready;

  // A channel being drained this cycle may be refilled in the same cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      logic drain;
      assign drain        = xfer & (sel_q == 2'(gi));
      assign in_ready[gi] = ~full_q[gi] | drain;
      assign load[gi]     = in_valid[gi] & in_ready[gi];
      assign full_d[gi]   = load[gi] | (full_q[gi] & ~drain);
      assign buf_d[gi]    = load[gi] ? in_data[gi*WIDTH +: WIDTH] : buf_q[gi];
    end
  endgenerate

`ifdef RR_SKIP_EMPTY_EN
  // Scan offsets 3..1 so the nearest full channel is the last to win.
  always_comb begin
    skip_sel = sel_q;
    for (int k = 3; k >= 1; k--) begin
      if (full_q[sel_q + 2'(k)]) begin
        skip_sel = sel_q + 2'(k);
      end
    end
  end
`else
  assign skip_sel = sel_q + 2'd1;
`endif

  always_comb begin
    sel_d = sel_q;
    if (xfer) begin
      sel_d = sel_q + 2'd1;
    end else if (!full_q[sel_q]) begin
      sel_d = skip_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      sel_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      sel_q  <= sel_d;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign a   = buf_q[0];
  assign b   = buf_q[1];
  assign c   = buf_q[2];
  assign d   = buf_q[3];
  assign sel = sel_q;

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed bench for mux_rr_feeder; expectations hold for both settings of RR_SKIP_EMPTY_EN.
module tb_mux_rr_feeder;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  a, b, c, d;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Downstream mux as it will be wired
  assign f = (sel == 2'd0) ? a : (sel == 2'd1) ? b : (sel == 2'd2) ? c : d;

  mux_rr_feeder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reset, let the pointer step three slots, then load so that sel lands on 0 with the words present.
  task automatic align_load(input logic [3:0] mask, input logic [15:0] data);
    do_reset();
    tick(); tick(); tick();
    in_valid = mask; in_data = data;
    tick();
    in_valid = '0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({d, c, b, a} !== 16'h0000) begin n_err++; $display("FAIL reset_bufs: got %h expected 0000", {d, c, b, a}); end
    n_cmp++; if (in_ready !== 4'b1111) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1111", in_ready); end
    rst = 1'b0;
    align_load(4'b1111, 16'h4321);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    tick();
    n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL midrst_sel: got %0d expected 0", sel); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({d, c, b, a} !== 16'h0000) begin n_err++; $display("FAIL midrst_bufs: got %h expected 0000", {d, c, b, a}); end
    n_cmp++; if (in_ready !== 4'b1111) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 1111", in_ready); end
    rst = 1'b0; out_ready = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_single_word;
    logic [1:0] exp_sel1;
`ifdef RR_SKIP_EMPTY_EN
    exp_sel1 = 2'd0;
`else
    exp_sel1 = 2'd1;
`endif
    do_reset();
    in_valid = 4'b0100; in_data = 16'h0500; out_ready = 1'b1;
    tick();
    in_valid = '0;
    #1;
    n_cmp++; if (sel !== exp_sel1) begin n_err++; $display("FAIL single_sel_e1: got %0d expected %0d", sel, exp_sel1); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_e1: got %b expected 0", out_valid); end
    n_cmp++; if (c !== 4'h5) begin n_err++; $display("FAIL single_c_loaded: got %h expected 5", c); end
    tick();
    n_cmp++; if (sel !== 2'd2) begin n_err++; $display("FAIL single_sel_e2: got %0d expected 2", sel); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_e2: got %b expected 1", out_valid); end
    n_cmp++; if (f !== 4'h5) begin n_err++; $display("FAIL single_f: got %h expected 5", f); end
    $display("single: xfer sel=%0d f=%h", sel, f);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b1111) begin n_err++; $display("FAIL single_in_ready_after: got %b expected 1111", in_ready); end
    n_cmp++; if (sel !== 2'd3) begin n_err++; $display("FAIL single_sel_after: got %0d expected 3", sel); end
    out_ready = 1'b0;
  endtask

  task automatic test_burst;
    logic [3:0] exp_f [4];
    exp_f[0] = 4'h0; exp_f[1] = 4'h2; exp_f[2] = 4'h4; exp_f[3] = 4'h8;
    align_load(4'b1111, 16'h8420);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (sel !== 2'(k)) begin n_err++; $display("FAIL burst_sel[%0d]: got %0d expected %0d", k, sel, k); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid[%0d]: got %b expected 1", k, out_valid); end
      n_cmp++; if (f !== exp_f[k]) begin n_err++; $display("FAIL burst_f[%0d]: got %h expected %h", k, f, exp_f[k]); end
      $display("burst: xfer sel=%0d f=%h", sel, f);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL burst_valid_end: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b1111) begin n_err++; $display("FAIL burst_in_ready_end: got %b expected 1111", in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    align_load(4'b0010, 16'h0020);
    tick();
    in_valid = 4'b0010; in_data = 16'h00F0; out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (sel !== 2'd1) begin n_err++; $display("FAIL bp_sel[%0d]: got %0d expected 1", k, sel); end
      n_cmp++; if (b !== 4'h2) begin n_err++; $display("FAIL bp_b[%0d]: got %h expected 2", k, b); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, out_valid); end
      n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready1[%0d]: got %b expected 0", k, in_ready[1]); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL bp_bypass_ready: got %b expected 1", in_ready[1]); end
    n_cmp++; if (f !== 4'h2) begin n_err++; $display("FAIL bp_xfer_f: got %h expected 2", f); end
    $display("backpressure: xfer sel=%0d f=%h", sel, f);
    tick();
    in_valid = '0; out_ready = 1'b0;
    #1;
    n_cmp++; if (b !== 4'hF) begin n_err++; $display("FAIL bp_reload_b: got %h expected f", b); end
    n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_reload_full: got %b expected 0", in_ready[1]); end
    n_cmp++; if (sel !== 2'd2) begin n_err++; $display("FAIL bp_sel_after: got %0d expected 2", sel); end
  endtask

  task automatic test_drain_refill;
    align_load(4'b0001, 16'h0003);
    out_ready = 1'b1; in_valid = 4'b0001; in_data = 16'h0009;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dr_valid: got %b expected 1", out_valid); end
    n_cmp++; if (f !== 4'h3) begin n_err++; $display("FAIL dr_f: got %h expected 3", f); end
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL dr_in_ready0: got %b expected 1", in_ready[0]); end
    $display("drain_refill: xfer sel=%0d f=%h", sel, f);
    tick();
    in_valid = '0; out_ready = 1'b0;
    #1;
    n_cmp++; if (a !== 4'h9) begin n_err++; $display("FAIL dr_a_new: got %h expected 9", a); end
    n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL dr_full0: got %b expected 0", in_ready[0]); end
    n_cmp++; if (sel !== 2'd1) begin n_err++; $display("FAIL dr_sel: got %0d expected 1", sel); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_w [4];
    logic [3:0] nv;
    int prev;
    exp_w[0] = 4'h1; exp_w[1] = 4'h2; exp_w[2] = 4'h3; exp_w[3] = 4'h4;
    prev = -1;
    align_load(4'b1111, 16'h4321);
    out_ready = 1'b1; in_valid = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 4; i++) begin
        nv = 4'((t * 4 + i + 5) & 15);
        in_data[i*4 +: 4] = nv;
      end
      #1;
      n_cmp++; if (sel !== 2'(t % 4)) begin n_err++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", t, sel, t % 4); end
      n_cmp++; if (f !== exp_w[t % 4]) begin n_err++; $display("FAIL rr_f[%0d]: got %h expected %h", t, f, exp_w[t % 4]); end
      n_cmp++; if (int'(sel) == prev) begin n_err++; $display("FAIL rr_repeat[%0d]: got sel %0d expected not %0d", t, sel, prev); end
      $display("rr: xfer %0d sel=%0d f=%h", t, sel, f);
      exp_w[t % 4] = 4'((t * 4 + (t % 4) + 5) & 15);
      prev = int'(sel);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid_end: got %b expected 1", out_valid); end
    in_valid = '0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_drain_refill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
